// File: rtl/rv_mem_arb_pkg.sv
// rv_arb_pkg: shared types and limits for the unified-memory arbiter.
//   arb_state_t : sequencer states (IDLE, ISSUE, WAIT, ACK)
//   arb_owner_t : which requester owns the current access
//   MEM_LAT_MIN/MEM_LAT_MAX : legal range of the memory read latency
//   LAT_W : width of the latency down-counter (holds up to MEM_LAT_MAX)
package rv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_W       = 4;

endpackage

// File: rtl/rv_mem_arb_if.sv
// rv_mem_arb_if: bundles the two requester ports and the memory port of the
// arbiter.
//   core_* : core control/datapath requester (req/we/addr/wdata in, rdata/ack out)
//   dbg_*  : debug/loader requester (same shape as core)
//   mem_*  : single memory port driven by the arbiter, mem_rdata returned
//   busy   : arbiter is mid-access
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters plus memory)
interface rv_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_ack;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output core_rdata, core_ack, dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  core_rdata, core_ack, dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rv_mem_arb_pick.sv
// rv_arb_pick: combinational grant selection.
//   core_req, dbg_req : pending request levels
//   starve_cnt        : consecutive core grants taken while debug waited
//   owner             : granted requester (meaningful when valid=1)
//   valid             : at least one request is pending
// Core has priority unless debug has been passed over STARVE_MAX times.
module rv_arb_pick
  import rv_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             core_req,
  input  logic             dbg_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output arb_owner_t       owner,
  output logic             valid
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  always_comb begin
    valid = core_req | dbg_req;
    owner = OWN_CORE;
    if (dbg_req && (!core_req || (starve_cnt >= STARVE_LIM))) begin
      owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: arbiter/sequencer for the unified memory of the multicycle core.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; aborts any access in flight
//   bus  : core and debug requester ports plus the memory port (slave view)
// One access at a time: IDLE picks and latches the request, ISSUE strobes
// mem_en for one cycle, WAIT counts down MEM_LAT cycles and captures read
// data on the last one, ACK pulses the owner's ack for one cycle.
module rv_mem_arb
  import rv_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic         clk,
  input  logic         rst,
  rv_mem_arb_if.slave  bus
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(MEM_LAT);

  if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_range
    $error("rv_mem_arb: MEM_LAT must be within 1..15");
  end

  arb_state_t       state;
  arb_owner_t       owner;
  logic [CNT_W-1:0] starve_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    core_rdata_q;
  logic [DW-1:0]    dbg_rdata_q;
  logic             core_ack_q;
  logic             dbg_ack_q;

  arb_owner_t       pick_owner;
  logic             pick_valid;

  rv_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .core_req   (bus.core_req),
    .dbg_req    (bus.dbg_req),
    .starve_cnt (starve_cnt),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_CORE;
      starve_cnt   <= '0;
      lat_cnt      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_owner;
            mem_en_q <= 1'b1;
            state    <= ISSUE;
            if (pick_owner == OWN_DBG) begin
              mem_we_q   <= bus.dbg_we;
              addr_q     <= bus.dbg_addr;
              wdata_q    <= bus.dbg_wdata;
              starve_cnt <= '0;
            end else begin
              mem_we_q <= bus.core_we;
              addr_q   <= bus.core_addr;
              wdata_q  <= bus.core_wdata;
              // Only core grants that bypass a waiting debug request count.
              if (bus.dbg_req && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          lat_cnt  <= LAT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            if (!mem_we_q) begin
              if (owner == OWN_DBG) dbg_rdata_q  <= bus.mem_rdata;
              else                  core_rdata_q <= bus.mem_rdata;
            end
            core_ack_q <= (owner == OWN_CORE);
            dbg_ack_q  <= (owner == OWN_DBG);
            state      <= ACK;
          end
        end
        ACK: begin
          core_ack_q <= 1'b0;
          dbg_ack_q  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbiter and sequencer for the single unified memory of the multicycle RISC-V core.
- Shares the memory between two requesters: the core's control/datapath (fetch, LW, SW) and a debug/loader port (program load, memory inspection).
- Owns the memory port. Issues one access at a time, waits a fixed memory latency, then returns read data with a one-cycle ack.
- The core control FSM holds its current state until core_ack.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- STARVE_MAX, 4, number of consecutive core grants while dbg_req is pending before debug is forced.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core access request, level, held until core_ack
- core_we  in  1  1=write, 0=read
- core_addr  in  AW  core byte address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  registered read data for core, valid in the core_ack cycle
- core_ack  out  1  one-cycle completion pulse to core
- dbg_req  in  1  debug access request, level, held until dbg_ack
- dbg_we  in  1  1=write
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_rdata  out  DW  registered read data for debug
- dbg_ack  out  1  one-cycle completion pulse to debug
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values (async on rst): state=IDLE, owner=CORE, all outputs 0, starve_cnt=0, lat_cnt=0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is high, pick an owner, latch that owner's we/addr/wdata into registers, go to ISSUE. Otherwise stay.
- Pick rule:
  - Only one requester high: that one wins.
  - Both high: DBG wins if starve_cnt >= STARVE_MAX, else CORE.
- starve_cnt:
  - +1 on each CORE pick made while dbg_req=1, saturating at STARVE_MAX.
  - Cleared on any DBG pick.
  - Unchanged otherwise.
- ISSUE: exactly one cycle. mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers. lat_cnt loads MEM_LAT. Next state is WAIT.
- WAIT: lat_cnt decrements each cycle. mem_en=0; mem_addr/mem_wdata hold the latched values.
  - In the cycle where lat_cnt==1 (ISSUE+MEM_LAT), mem_rdata is valid.
  - For reads, it is captured at that cycle's end into the owner's rdata register. The other requester's rdata is untouched.
  - Next state is ACK.
- ACK: the owner's ack=1 for exactly one cycle, then IDLE. No new pick is made in ACK.
- Writes use the same sequence with uniform latency; rdata registers are not updated on writes.
- Latency: request high in IDLE cycle T → mem_en at T+1 → ack at T+MEM_LAT+2. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- Request inputs are sampled only in IDLE. Changes to we/addr/wdata after the pick are ignored.
- A requester dropping req mid-transaction does not abort it. The access completes and ack still pulses.
- The requester may not re-raise req in its ack cycle expecting the same access. The level seen in the following IDLE cycle is a new request.
- Only the owner's ack ever pulses. core_ack and dbg_ack are never high together.
- An asserted rst mid-transaction aborts immediately:
  - state goes to IDLE and no ack is issued;
  - any write already strobed by mem_en is not undone.
- The MEM_LAT range is checked by a synthesis-time assertion.

Decomposition:
- Package rv_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, ACK};
  - owner enum arb_owner_t {OWN_CORE, OWN_DBG};
  - constants for the MEM_LAT range limits.
- One combinational sub-module, rv_arb_pick. It takes core_req, dbg_req, starve_cnt and STARVE_MAX and returns the granted owner plus a valid flag. It is reusable if a third requester is added.

Test Plan:
- Core read only, MEM_LAT=2, memory preloaded with 0x12345678 at addr 0x40:
  - core_req at cycle 0 → mem_en=1 at cycle 1 with addr 0x40 and mem_we=0;
  - core_ack at cycle 4 with core_rdata=0x12345678; busy low at cycle 5.
- Debug write 0xDEADBEEF to 0x100, then core read of 0x100:
  - dbg_ack pulses once and core_ack does not;
  - the subsequent core read returns 0xDEADBEEF; dbg_rdata is unchanged.
- Both requesters held high continuously, STARVE_MAX=4:
  - grant order is CORE, CORE, CORE, CORE, DBG, then repeats;
  - starve_cnt reads 0 immediately after each DBG grant.
- core_req dropped in the WAIT state:
  - the access still completes and core_ack pulses at T+MEM_LAT+2;
  - no second mem_en occurs.
- rst asserted during WAIT:
  - outputs go to 0 asynchronously and no ack pulses;
  - after release, a fresh core request completes with normal latency.
- MEM_LAT=1 and MEM_LAT=5 sweeps: request-to-ack is exactly 3 and 7 cycles respectively, for both reads and writes.
